// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU take 32 iterations plus one sign-fix cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;      // multiply: {partial product, multiplier}; divide: low half is dividend/quotient
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             b_zero_q;
  logic             busy_q;
  logic             done_q;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign sgn   = ~op_i[0];
  assign a_neg = sgn & a_i[WIDTH-1];
  assign b_neg = sgn & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // A set top remainder bit would always exceed the divisor, so it forces a subtract.
  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_ok    = ~div_diff[WIDTH+1] | rem_q[WIDTH];
  assign rem_next  = div_ok ? div_diff[WIDTH:0] : div_shift;
  assign quo_next  = {acc_q[WIDTH-2:0], div_ok};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = b_zero_q ? {WIDTH{1'b1}} :
                    (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mthi_i) hi_q <= wdata_i;
          if (mtlo_i) lo_q <= wdata_i;
          if (start_i && !cancel_i) begin
            is_div_q  <= op_i[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            b_zero_q  <= (b_i == '0);
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_CALC;
            if (op_i[1]) begin
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
              opnd_q <= a_mag;
            end
          end
        end
        S_CALC: begin
          if (cancel_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (is_div_q) begin
              rem_q               <= rem_next;
              acc_q[WIDTH-1:0]    <= quo_next;
            end else begin
              acc_q <= mul_next;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!cancel_i) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the MIPS EXE stage, alongside the single-cycle ALU.
- Where the ALU returns a combinational result, this block takes MULT/MULTU/DIV/DIVU over a start/busy/done handshake.
- Computes radix-2, one bit per cycle, and owns the architectural HI/LO registers.
- Pipeline control stalls on busy and flushes via cancel.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  32  rs operand (multiplicand / dividend)
- b  input  32  rt operand (multiplier / divisor)
- cancel  input  1  pipeline flush: abort the in-flight operation
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in progress; pipeline must stall MFHI/MFLO/MD ops
- done  output  1  one-cycle pulse; HI/LO hold the new result this cycle
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE, hi=0, lo=0, busy=0, done=0, and all internal working registers are cleared. rst overrides every other input, including mid-operation.

States:
- IDLE:
  - start=1 and cancel=0: latch op, a, b; compute operand magnitudes (signed ops only; unsigned ops take a and b as-is); record result signs; go to CALC with counter=0.
- CALC:
  - Runs 32 cycles, one iteration per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 33-bit partial remainder, 32-bit quotient.
  - After counter=31, go to FIX.
- FIX (one cycle):
  - Apply the sign correction:
    - Product is negated when the signs of a and b differ.
    - Quotient is negated when the signs differ.
    - Remainder takes the sign of a.
  - At the edge ending FIX: write hi/lo, set done=1, return to IDLE.

Timing:
- start accepted at edge E.
- busy=1 for the 33 cycles following E (CALC plus FIX).
- At edge E+33, hi/lo update and done=1. done is high for exactly one cycle, with busy=0.
- Total latency start-to-done is 34 cycles, identical for all ops and for all operand values.

Results:
- MULT/MULTU: {hi,lo} = 64-bit product.
- DIV/DIVU: lo = quotient, hi = remainder.

Boundary conditions:
- Divide by zero (b=0, DIV or DIVU): same 34-cycle latency; lo=32'hFFFFFFFF, hi=a unmodified. No sign fix.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0 (two's-complement wrap, no trap).
- MULT 32'h80000000 * 32'h80000000: {hi,lo}=64'h4000000000000000.

Handshake and edge cases:
- start while busy=1: ignored; no queueing.
- start in the done cycle: accepted, because the block is in IDLE.
- cancel=1 in CALC or FIX: next state IDLE; hi/lo unchanged; no done pulse; busy=0 on the next cycle.
- cancel=1 in IDLE: any simultaneous start is ignored.
- mthi/mtlo are honoured only in IDLE. While busy they are ignored; control guarantees they are stalled.
- mthi/mtlo together with start in IDLE: the write is applied, and the operation is still launched. Its completion later overwrites both HI and LO.
- mthi and mtlo in the same cycle: both are written with wdata.
- a/b/op may change after start; only the values latched at acceptance are used.

Test Plan:
- MULT a=32'hFFFFFFFD (-3), b=5 -> done at cycle 34 after start; hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; busy high exactly 33 cycles.
- MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Also MULT with a=b=32'h80000000 -> hi=32'h40000000, lo=0.
- DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Then DIVU a=100, b=7 -> lo=14, hi=2. Then DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIVU a=100, b=0 -> after 34 cycles lo=32'hFFFFFFFF, hi=100.
- Abort and retry:
  - mtlo with wdata=32'h12345678 in IDLE, then MULT 3*4.
  - Assert cancel on cycle 10 -> busy drops next cycle, no done pulse; hi=0, lo=32'h12345678.
  - A second start pulsed while busy (before the cancel) must have no effect.
- Reset mid-operation: DIVU 1000/3, rst at cycle 20 -> hi=lo=0, busy=0, no done. A new MULTU 6*7 started afterwards -> lo=42, hi=0. Also start in the done cycle is accepted back-to-back.
